// File: rtl/exec_unit_pkg.sv
// Shared constants for the execution unit: opcodes, FSM state codes and flag bit positions.
package exec_unit_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD_A = 3'd1;
    localparam state_t ST_RD_B = 3'd2;
    localparam state_t ST_EXEC = 3'd3;
    localparam state_t ST_WB   = 3'd4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    function automatic logic is_reserved(input logic [3:0] op);
        if (op > OP_CMP) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/eu_regfile.sv
// Register file: one synchronous write port, operand and debug combinational read ports.
module eu_regfile #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_r [DEPTH];

    // storage write and synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata    = mem_r[raddr];
    assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: read A, read B (or immediate), execute, write back; host load and debug ports.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    opcode,
    input  logic          use_imm,
    input  logic [DW-1:0] number,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] out1,
    output logic [3:0]    flag1
);

    state_t        state_r, state_nx_s;
    logic [3:0]    op_r;
    logic          imm_r;
    logic [DW-1:0] num_r, opa_r, opb_r, out1_r;
    logic [AW-1:0] a1_r, a2_r, a3_r;
    logic [3:0]    flag1_r;
    logic          busy_r, done_r, err_r;
    logic [AW-1:0] rd_addr_s, wr_addr_s;
    logic [DW-1:0] rd_data_s, wr_data_s;
    logic          wb_en_s, ld_ok_s, we_s;
    logic [DW+3:0] alu_s;

    // Returns {flags, result}; flags ordered {V,N,C,Z}.
    function automatic logic [DW+3:0] alu(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [DW:0]   ext;
        logic [DW-1:0] r;
        logic [3:0]    f;
        logic          c, v;
        ext = {(DW+1){1'b0}};
        r   = a;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                r   = ext[DW-1:0];
                c   = ext[DW];
                v   = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            OP_SUB, OP_CMP: begin
                ext = {1'b0, a} - {1'b0, b};
                r   = ext[DW-1:0];
                c   = ext[DW];
                v   = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: begin
                r = {a[DW-2:0], 1'b0};
                c = a[DW-1];
            end
            OP_SHR: begin
                r = {1'b0, a[DW-1:1]};
                c = a[0];
            end
            OP_MOV: r = b;
            default: r = a;
        endcase
        f         = 4'b0000;
        f[FLAG_Z] = (r == {DW{1'b0}});
        f[FLAG_N] = r[DW-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return {f, r};
    endfunction

    // next-state decode
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_RD_A;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RD_A: state_nx_s = ST_RD_B;
            ST_RD_B: state_nx_s = ST_EXEC;
            ST_EXEC: state_nx_s = ST_WB;
            ST_WB:   state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // register-file port muxing: write-back has priority, host load only when idle and not starting
    always_comb begin
        rd_addr_s = (state_r == ST_RD_A) ? a1_r : a2_r;
        wb_en_s   = (state_r == ST_WB) && (op_r != OP_CMP) && !is_reserved(op_r);
        ld_ok_s   = (state_r == ST_IDLE) && !start && ld_en;
        we_s      = wb_en_s || ld_ok_s;
        if (wb_en_s) begin
            wr_addr_s = a3_r;
            wr_data_s = out1_r;
        end else begin
            wr_addr_s = ld_addr;
            wr_data_s = ld_data;
        end
    end

    assign alu_s = alu(op_r, opa_r, opb_r);

    // sequencer, operand latches and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            op_r    <= 4'd0;
            imm_r   <= 1'b0;
            num_r   <= {DW{1'b0}};
            a1_r    <= {AW{1'b0}};
            a2_r    <= {AW{1'b0}};
            a3_r    <= {AW{1'b0}};
            opa_r   <= {DW{1'b0}};
            opb_r   <= {DW{1'b0}};
            out1_r  <= {DW{1'b0}};
            flag1_r <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= (state_r == ST_WB);
            err_r   <= (state_r == ST_WB) && is_reserved(op_r);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r  <= opcode;
                        imm_r <= use_imm;
                        num_r <= number;
                        a1_r  <= addr1;
                        a2_r  <= addr2;
                        a3_r  <= addr3;
                    end
                end
                ST_RD_A: opa_r <= rd_data_s;
                ST_RD_B: opb_r <= imm_r ? num_r : rd_data_s;
                ST_EXEC: begin
                    if (!is_reserved(op_r)) begin
                        out1_r  <= alu_s[DW-1:0];
                        flag1_r <= alu_s[DW+3:DW];
                    end
                end
                default: ;
            endcase
        end
    end

    eu_regfile #(.DW(DW), .AW(AW)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (we_s),
        .waddr    (wr_addr_s),
        .wdata    (wr_data_s),
        .raddr    (rd_addr_s),
        .rdata    (rd_data_s),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign out1  = out1_r;
    assign flag1 = flag1_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: driver queues expected results, negedge monitor checks every done pulse.
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       rst, start, use_imm, ld_en;
    logic [3:0] opcode;
    logic [7:0] number, ld_data, dbg_data, out1;
    logic [4:0] addr1, addr2, addr3, ld_addr, dbg_addr;
    logic       busy, done, err;
    logic [3:0] flag1;

    typedef struct {
        logic [7:0] out1;
        logic [3:0] flag1;
        logic       err;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] eo;
        logic [3:0] ef;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    exec_unit #(.DW(8), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .use_imm(use_imm),
        .number(number), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy), .done(done), .err(err), .out1(out1), .flag1(flag1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic dbg_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(nm, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    task automatic load(input logic [4:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    function automatic exp_t mk(input logic [7:0] eo, input logic [3:0] ef, input logic ee);
        exp_t e;
        e.out1  = eo;
        e.flag1 = ef;
        e.err   = ee;
        e.cyc   = cyc + 5;
        return e;
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
    task automatic issue(input logic [3:0] op, input logic [4:0] x1, input logic [4:0] x2,
                         input logic [4:0] x3, input logic im, input logic [7:0] num,
                         input logic [7:0] eo, input logic [3:0] ef, input logic ee);
        start = 1'b1; opcode = op; addr1 = x1; addr2 = x2; addr3 = x3;
        use_imm = im; number = num;
        sb.push_back(mk(eo, ef, ee));
        @(negedge clk);
        start   = 1'b0;
        opcode  = 4'($urandom);
        addr1   = 5'($urandom);
        addr2   = 5'($urandom);
        addr3   = 5'($urandom);
        use_imm = 1'($urandom);
        number  = 8'($urandom);
        chk("busy_during_op", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        chk("busy_after_op", {31'd0, busy}, 32'd0);
    endtask

    // monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_latency", cyc, mon_e.cyc);
                chk("out1", {24'd0, out1}, {24'd0, mon_e.out1});
                chk("flag1", {28'd0, flag1}, {28'd0, mon_e.flag1});
                chk("err", {31'd0, err}, {31'd0, mon_e.err});
            end
        end else if (err !== 1'b0) begin
            chk("err_without_done", {31'd0, err}, 32'd0);
        end
    end

    initial begin
        vec_t vt[5];
        vt[0] = '{4'd2, 8'h30, 4'b0000};
        vt[1] = '{4'd3, 8'hFC, 4'b0100};
        vt[2] = '{4'd4, 8'hCC, 4'b0100};
        vt[3] = '{4'd5, 8'h0F, 4'b0000};
        vt[4] = '{4'd6, 8'hE0, 4'b0110};

        rst = 1'b1; start = 1'b0; opcode = 4'd0; use_imm = 1'b0; number = 8'd0;
        addr1 = 5'd0; addr2 = 5'd0; addr3 = 5'd0; ld_en = 1'b0; ld_addr = 5'd0;
        ld_data = 8'd0; dbg_addr = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_out1", {24'd0, out1}, 32'd0);
        chk("rst_flag1", {28'd0, flag1}, 32'd0);
        rst = 1'b0;

        load(5'd1, 8'h7F);
        load(5'd2, 8'h01);
        dbg_chk("dbg_r1_load", 5'd1, 8'h7F);
        issue(4'd0, 5'd1, 5'd2, 5'd3, 1'b0, 8'h00, 8'h80, 4'b1100, 1'b0);
        dbg_chk("dbg_r3_add", 5'd3, 8'h80);

        load(5'd4, 8'h03);
        load(5'd5, 8'h05);
        issue(4'd9, 5'd4, 5'd5, 5'd6, 1'b0, 8'h00, 8'hFE, 4'b0110, 1'b0);
        dbg_chk("dbg_r6_cmp", 5'd6, 8'h00);
        issue(4'd1, 5'd5, 5'd5, 5'd6, 1'b0, 8'h00, 8'h00, 4'b0001, 1'b0);
        dbg_chk("dbg_r6_sub", 5'd6, 8'h00);

        issue(4'd8, 5'd0, 5'd0, 5'd7, 1'b1, 8'hA5, 8'hA5, 4'b0100, 1'b0);
        dbg_chk("dbg_r7_mov", 5'd7, 8'hA5);
        load(5'd8, 8'h81);
        issue(4'd7, 5'd8, 5'd0, 5'd9, 1'b0, 8'h00, 8'h40, 4'b0010, 1'b0);
        dbg_chk("dbg_r9_shr", 5'd9, 8'h40);

        load(5'd16, 8'hF0);
        load(5'd17, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            issue(vt[i].op, 5'd16, 5'd17, 5'd18, 1'b0, 8'h00, vt[i].eo, vt[i].ef, 1'b0);
            dbg_chk("dbg_r18_logic", 5'd18, vt[i].eo);
        end

        // start held across two instructions; second depends on first's destination
        start = 1'b1; opcode = 4'd0; addr1 = 5'd1; addr2 = 5'd2; addr3 = 5'd10; use_imm = 1'b0;
        sb.push_back(mk(8'h80, 4'b1100, 1'b0));
        @(negedge clk);
        addr1 = 5'd10; addr2 = 5'd2; addr3 = 5'd11;
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 5'd12; ld_data = 8'h55;
        @(negedge clk);
        ld_en = 1'b0;
        repeat (2) @(negedge clk);
        sb.push_back(mk(8'h81, 4'b0100, 1'b0));
        ld_en = 1'b1; ld_addr = 5'd13; ld_data = 8'h66;
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        chk("busy_second", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        dbg_chk("dbg_r10_first", 5'd10, 8'h80);
        dbg_chk("dbg_r11_chain", 5'd11, 8'h81);
        dbg_chk("dbg_r12_ld_busy", 5'd12, 8'h00);
        dbg_chk("dbg_r13_ld_start", 5'd13, 8'h00);

        // reserved opcode: err with done, destination untouched, result regs hold
        issue(4'hC, 5'd1, 5'd2, 5'd1, 1'b0, 8'h00, 8'h81, 4'b0100, 1'b1);
        dbg_chk("dbg_r1_reserved", 5'd1, 8'h7F);

        // reset while in RD_B aborts the instruction
        start = 1'b1; opcode = 4'd0; addr1 = 5'd1; addr2 = 5'd2; addr3 = 5'd15; use_imm = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_out1", {24'd0, out1}, 32'd0);
        chk("abort_flag1", {28'd0, flag1}, 32'd0);
        dbg_chk("abort_r1", 5'd1, 8'h00);
        repeat (6) @(negedge clk);
        dbg_chk("abort_r15", 5'd15, 8'h00);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised execution unit: accepts one register-to-register instruction at a time, reads two operands from an internal single-write register file, evaluates them in an ALU, and writes the result back. Successor to the 8-bit fixed execution unit. Adds configurable data width and depth, an immediate-operand mode, a compare-only opcode, a start/busy/done handshake, a host load port and a debug read port. Sits between the instruction decoder (drives start/opcode/addresses) and the host/test harness (preloads and inspects registers).

## Interface
- DW, 8, data width (≥4)
- AW, 5, register address width; depth = 2**AW
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  instruction request, sampled only in IDLE
- opcode  in  4  operation, encoding below
- use_imm  in  1  1: operand B = number instead of reg[addr2]
- number  in  DW  immediate operand
- addr1, addr2, addr3  in  AW  operand A, operand B, destination addresses
- ld_en  in  1  host write strobe, honoured only in IDLE
- ld_addr  in  AW; ld_data  in  DW  host write address/data
- dbg_addr  in  AW; dbg_data  out  DW  combinational read of reg[dbg_addr]
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for reserved opcode
- out1  out  DW  last registered result
- flag1  out  4  {V,N,C,Z} of last executed op

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical), 8 MOV (B), 9 CMP (SUB, no write-back), 10–15 reserved.
- Z = result==0; N = result[DW-1]. ADD: C = carry-out, V = signed overflow. SUB/CMP: C = borrow (A<B unsigned), V = signed overflow. SHL: C = A[DW-1]; SHR: C = A[0]; V=0. AND/OR/XOR/NOT/MOV: C=0, V=0. All arithmetic modulo 2**DW.
- FSM: IDLE → RD_A → RD_B → EXEC → WB → IDLE.
  - IDLE: on start, latch opcode, use_imm, number, addr1–3; go RD_A. Else if ld_en, reg[ld_addr] ← ld_data.
  - RD_A: opa ← reg[addr1]. RD_B: opb ← use_imm ? number : reg[addr2].
  - EXEC: out1, flag1 ← ALU(opa, opb). Reserved opcode: out1, flag1 unchanged.
  - WB: reg[addr3] ← out1 unless CMP or reserved. Assert done (err if reserved) in the following cycle.
- Latched fields are used throughout; input changes after acceptance have no effect.
- start while busy: ignored, not queued. ld_en while busy: ignored, register file untouched.
- addr3 may equal addr1/addr2; operands already latched, no hazard.

## Timing
- Reset: state IDLE; busy, done, err = 0; out1 = 0; flag1 = 0; all registers = 0. Reset in any state aborts: no write-back, no done.
- Start sampled at edge E0. busy high E0+ through E4. Write-back commits at E4. done/err high for the single cycle after E4, while state is already IDLE. Fixed latency 5 cycles for every opcode.
- A start held high during the done cycle is accepted at E5; throughput one instruction per 5 cycles. The new instruction sees the prior write.
- dbg_data is combinational and reflects a write from the cycle after its commit edge.
- ld_en and start in the same IDLE cycle: start wins, load dropped.

## Structure
- Package exec_unit_pkg: opcode constants, FSM state enum, flag bit indices (Z=0, C=1, N=2, V=3).
- Sub-module eu_regfile: 2**AW × DW, one synchronous write port (muxed WB/host), two combinational read ports (operand, debug), synchronous clear on rst.
- ALU is a combinational function/always block inside exec_unit; not a separate instance.

## Test plan
- Load reg1=0x7F, reg2=0x01; ADD 1,2→3 → done 5 cycles after start, out1=0x80, flag1=4'b1100, dbg reg3=0x80.
- reg4=0x03, reg5=0x05; CMP 4,5→6 → flag1=4'b0110, reg6 stays 0; SUB 5,5→6 → out1=0, flag1=4'b0001, reg6=0.
- use_imm=1, number=0xA5, MOV →7 → reg7=0xA5. SHR on 0x81 → 0x40, C=1.
- start held high over two ADDs where the second reads the first's addr3 → second result uses the updated value; start and ld_en pulsed mid-op ignored.
- rst asserted in RD_B → next cycle busy=0, outputs/registers 0, no done.
- Opcode 0xC → done and err pulse together, no write, flag1/out1 unchanged.
